signed_divmod_seq: RTL

Multi-cycle signed divide/modulo unit that computes the truncating quotient and remainder of two signed operands with SystemVerilog `/` and `%` semantics. It sits beside the combinational signed-ops stage and replaces its single-cycle divider where timing forbids one. Operands are taken in over a valid/ready handshake, and results are delivered the same way. Division by zero gives defined, flagged results rather than X.

---
 rtl/signed_divmod_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/signed_divmod_seq.sv
// Multi-cycle signed divide/modulo: restoring division on operand magnitudes,
// one quotient bit per cycle, then a sign fix-up, with valid/ready on both sides.
module signed_divmod_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sa,
  input  logic [WIDTH-1:0] in_sb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sdiv,
  output logic [WIDTH-1:0] out_smod,
  output logic             out_div_zero,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);
  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MINUS_ONE = '1;

  typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, DONE} state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] sa_p0;
  logic signed [WIDTH-1:0] sb_p0;
  logic [WIDTH-1:0]        dvs_p0;
  logic [WIDTH-1:0]        quo_p1;
  logic [WIDTH-1:0]        rem_p1;
  logic [CNT_W-1:0]        cnt_p1;
  logic [WIDTH:0]          shifted;
  logic [WIDTH:0]          trial;

  // Magnitude as an unsigned value; the most-negative input maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    mag = v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  // Two's-complement negate with wrap to WIDTH bits.
  function automatic logic [WIDTH-1:0] neg_if(input logic en, input logic [WIDTH-1:0] v);
    neg_if = en ? (~v + 1'b1) : v;
  endfunction

  assign in_ready = (state == IDLE);

  // The dividend magnitude shifts out of quo_p1 MSB-first while quotient bits shift in.
  always_comb begin
    shifted = {rem_p1, quo_p1[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_p0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sa_p0        <= '0;
      sb_p0        <= '0;
      dvs_p0       <= '0;
      quo_p1       <= '0;
      rem_p1       <= '0;
      cnt_p1       <= '0;
      out_valid    <= 1'b0;
      out_sdiv     <= '0;
      out_smod     <= '0;
      out_div_zero <= 1'b0;
      out_ovf      <= 1'b0;
    end else begin
      case (state)
        // Stage p0: operand capture
        IDLE: begin
          if (in_valid) begin
            sa_p0 <= in_sa;
            sb_p0 <= in_sb;
            if (in_sb == '0) begin
              out_sdiv     <= '0;
              out_smod     <= '0;
              out_div_zero <= 1'b1;
              out_ovf      <= 1'b0;
              out_valid    <= 1'b1;
              state        <= DONE;
            end else begin
              quo_p1 <= mag(in_sa);
              dvs_p0 <= mag(in_sb);
              rem_p1 <= '0;
              cnt_p1 <= '0;
              state  <= DIVIDE;
            end
          end
        end
        // Stage p1: restoring iterations
        DIVIDE: begin
          if (!trial[WIDTH]) begin
            rem_p1 <= trial[WIDTH-1:0];
            quo_p1 <= {quo_p1[WIDTH-2:0], 1'b1};
          end else begin
            rem_p1 <= shifted[WIDTH-1:0];
            quo_p1 <= {quo_p1[WIDTH-2:0], 1'b0};
          end
          cnt_p1 <= cnt_p1 + 1'b1;
          if (cnt_p1 == LAST_IT) state <= FIXUP;
        end
        // Stage p2: sign fix-up into the output registers
        FIXUP: begin
          out_sdiv     <= neg_if(sa_p0[WIDTH-1] ^ sb_p0[WIDTH-1], quo_p1);
          out_smod     <= neg_if(sa_p0[WIDTH-1], rem_p1);
          out_div_zero <= 1'b0;
          out_ovf      <= (sa_p0 == MOST_NEG) && (sb_p0 == MINUS_ONE);
          out_valid    <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
